pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline controller: merges per-stage stall requests into a per-stage stall vector
//  consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and sequences exception/ERTN
//  flushes: latch redirect target, flush every stage register, then issue one PC redirect pulse.
//  Also runs a stall watchdog that flags a stuck pipeline for debug.
// PARAMETERS
//  FLUSH_CYCLES   1     cycles flush stays high per event (1..15)
//  STALL_TIMEOUT  1024  consecutive stalled cycles before stall_timeout sets (>=2)
//  PC_W           32    redirect address width
// PORTS
//  clk             in   1     clock
//  rst             in   1     synchronous, active-high reset
//  stallreq_if     in   1     IF needs hold
//  stallreq_id     in   1     ID needs hold (load-use etc.)
//  stallreq_ex     in   1     EX needs hold (multi-cycle mul/div)
//  stallreq_mem    in   1     MEM needs hold (dcache miss)
//  excp_req        in   1     exception raised by instruction in MEM
//  ertn_req        in   1     ERTN committing in MEM
//  excp_entry      in   PC_W  exception entry address (CSR EENTRY)
//  era             in   PC_W  return address (CSR ERA)
//  stall           out  6     [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB; 1=hold
//  flush           out  1     clear all stage registers to bubble
//  new_pc          out  PC_W  redirect target
//  new_pc_valid    out  1     one-cycle redirect strobe
//  busy            out  1     flush sequence in progress
//  stall_timeout   out  1     sticky watchdog flag
// BEHAVIOUR
//  Reset: state=IDLE; stall=0, flush=0, new_pc=0, new_pc_valid=0, busy=0, stall_timeout=0,
//   flush counter=0, watchdog counter=0. Reset wins over any input, including mid-flush.
//  Stall vector (combinational, IDLE only): highest requesting stage wins, holds it and all
//   upstream: mem->6'b011111, ex->6'b001111, id->6'b000111, if->6'b000011, none->0.
//   WB bit [5] never set. In FLUSH stall=0.
//  FSM states IDLE, FLUSH.
//   IDLE: excp_req|ertn_req at cycle T -> latch target (excp_entry if excp_req, else era;
//    excp_req wins if both), cnt<=FLUSH_CYCLES-1, go FLUSH. Stall requests in cycle T still
//    drive stall in T (instruction in MEM is not yet flushed).
//   FLUSH: flush=1, busy=1, cycles T+1..T+FLUSH_CYCLES; cnt decrements each cycle;
//    at cnt==0: new_pc_valid=1 with new_pc=latched target (cycle T+FLUSH_CYCLES), next IDLE.
//   excp_req/ertn_req/stallreq_* ignored during FLUSH (not queued).
//  flush, busy, new_pc_valid are registered outputs; new_pc holds last target after strobe.
//  Back-to-back: a new excp_req in the cycle after returning to IDLE is accepted normally.
//  Watchdog: counter increments each cycle stall!=0, clears when stall==0 or in FLUSH;
//   saturates at STALL_TIMEOUT; on reaching it stall_timeout<=1, stays 1 until rst.
//   Counter width $clog2(STALL_TIMEOUT+1); no wrap.
// TESTING
//  1 stallreq_id=1 only -> stall=6'b000111 same cycle; add stallreq_mem=1 -> 6'b011111.
//  2 excp_req=1 at T, excp_entry=32'h1c00_8000, FLUSH_CYCLES=1 -> flush=1 at T+1,
//    new_pc_valid=1 & new_pc=32'h1c00_8000 at T+1, busy=0 at T+2.
//  3 excp_req & ertn_req together, era=32'h1c00_0100 -> new_pc=excp_entry; FLUSH_CYCLES=3 ->
//    flush high T+1..T+3, strobe only at T+3, stallreq_ex during flush -> stall=0.
//  4 rst asserted at T+1 of a 3-cycle flush -> T+2 all outputs 0, no redirect strobe.
//  5 stallreq_mem held 1023 cycles (STALL_TIMEOUT=1024) -> timeout 0; held 1024 -> timeout 1
//    and stays 1 after stall drops; stall gap of one cycle at 1000 -> counter restarts.
//  6 ertn_req alone at T, era=32'h1c00_0100 -> new_pc=32'h1c00_0100 strobe at T+FLUSH_CYCLES.

Source files
------------

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
//   Central pipeline controller.
//   - Merges per-stage stall requests into a per-stage hold vector. The highest
//     requesting stage wins and holds itself plus everything upstream of it.
//   - Sequences exception / ERTN flushes: the redirect target is latched, every
//     stage register is flushed for FLUSH_CYCLES cycles, and a single-cycle PC
//     redirect strobe is issued in the last flush cycle.
//   - Runs a stall watchdog that sets a sticky flag once the pipeline has been
//     stalled for STALL_TIMEOUT consecutive cycles.
//
// Ports
//   clk            clock
//   rst            synchronous, active-high reset
//   stallreq_if    IF needs hold
//   stallreq_id    ID needs hold (load-use etc.)
//   stallreq_ex    EX needs hold (multi-cycle mul/div)
//   stallreq_mem   MEM needs hold (dcache miss)
//   excp_req       exception raised by the instruction in MEM
//   ertn_req       ERTN committing in MEM
//   excp_entry     exception entry address
//   era            exception return address
//   stall[5:0]     [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB, 1 = hold
//   flush          clear all stage registers to bubble (registered)
//   new_pc         redirect target, holds the last target after the strobe
//   new_pc_valid   one-cycle redirect strobe (registered)
//   busy           flush sequence in progress (registered)
//   stall_timeout  sticky watchdog flag (registered)
// ----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 1024,
    parameter int PC_W          = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallreq_if,
    input  logic            stallreq_id,
    input  logic            stallreq_ex,
    input  logic            stallreq_mem,
    input  logic            excp_req,
    input  logic            ertn_req,
    input  logic [PC_W-1:0] excp_entry,
    input  logic [PC_W-1:0] era,
    output logic [5:0]      stall,
    output logic            flush,
    output logic [PC_W-1:0] new_pc,
    output logic            new_pc_valid,
    output logic            busy,
    output logic            stall_timeout
);

    localparam int             WD_W     = $clog2(STALL_TIMEOUT + 1);
    localparam logic [3:0]     CNT_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(STALL_TIMEOUT);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_next_s;
    logic [PC_W-1:0]   target_r;
    logic [PC_W-1:0]   target_next_s;
    logic [PC_W-1:0]   new_pc_r;
    logic [PC_W-1:0]   new_pc_next_s;
    logic              flush_r;
    logic              flush_next_s;
    logic              busy_r;
    logic              valid_r;
    logic              valid_next_s;
    logic [WD_W-1:0]   wd_cnt_r;
    logic [WD_W-1:0]   wd_cnt_next_s;
    logic              timeout_r;
    logic              timeout_next_s;
    logic [5:0]        stall_s;

    // Stall priority encoder: the deepest requesting stage holds itself and all upstream stages.
    always_comb begin
        stall_s = 6'b000000;
        if (state_r == ST_IDLE) begin
            if (stallreq_mem) begin
                stall_s = 6'b011111;
            end else if (stallreq_ex) begin
                stall_s = 6'b001111;
            end else if (stallreq_id) begin
                stall_s = 6'b000111;
            end else if (stallreq_if) begin
                stall_s = 6'b000011;
            end else begin
                stall_s = 6'b000000;
            end
        end else begin
            // Everything is being flushed, so nothing needs to hold.
            stall_s = 6'b000000;
        end
    end

    // Flush sequencer next-state logic; flush/strobe are computed one cycle early so they can be registered.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        target_next_s = target_r;
        flush_next_s  = 1'b0;
        valid_next_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (excp_req || ertn_req) begin
                    // Exception takes priority over a simultaneous ERTN.
                    if (excp_req) begin
                        target_next_s = excp_entry;
                    end else begin
                        target_next_s = era;
                    end
                    cnt_next_s   = CNT_INIT;
                    state_next_s = ST_FLUSH;
                    flush_next_s = 1'b1;
                    valid_next_s = (CNT_INIT == 4'd0);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_IDLE;
                end else begin
                    cnt_next_s   = cnt_r - 4'd1;
                    flush_next_s = 1'b1;
                    // The strobe lands in the final flush cycle, i.e. when the counter reaches zero.
                    valid_next_s = (cnt_r == 4'd1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Redirect address only changes when a strobe is about to be presented.
    always_comb begin
        if (valid_next_s) begin
            new_pc_next_s = target_next_s;
        end else begin
            new_pc_next_s = new_pc_r;
        end
    end

    // Watchdog: count consecutive stalled cycles, saturate at the limit, latch the sticky flag.
    always_comb begin
        if ((state_r == ST_FLUSH) || (stall_s == 6'b000000)) begin
            wd_cnt_next_s = {WD_W{1'b0}};
        end else if (wd_cnt_r == WD_MAX) begin
            wd_cnt_next_s = wd_cnt_r;
        end else begin
            wd_cnt_next_s = wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
        end
        if (wd_cnt_next_s == WD_MAX) begin
            timeout_next_s = 1'b1;
        end else begin
            timeout_next_s = timeout_r;
        end
    end

    // State and output registers with synchronous reset; reset overrides any in-flight flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            target_r  <= {PC_W{1'b0}};
            new_pc_r  <= {PC_W{1'b0}};
            flush_r   <= 1'b0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            wd_cnt_r  <= {WD_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            target_r  <= target_next_s;
            new_pc_r  <= new_pc_next_s;
            flush_r   <= flush_next_s;
            busy_r    <= flush_next_s;
            valid_r   <= valid_next_s;
            wd_cnt_r  <= wd_cnt_next_s;
            timeout_r <= timeout_next_s;
        end
    end

    assign stall         = stall_s;
    assign flush         = flush_r;
    assign busy          = busy_r;
    assign new_pc        = new_pc_r;
    assign new_pc_valid  = valid_r;
    assign stall_timeout = timeout_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl
//   Two pipe_ctrl instances share all inputs: u_dut3 (3-cycle flush) and
//   u_dut1 (1-cycle flush). Expected redirects (target + cycle) are queued when
//   a request is issued; monitor processes pop and compare on every strobe.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_req, ertn_req;
    logic [31:0] excp_entry, era;

    logic [5:0]  stall3, stall1;
    logic        flush3, flush1, npv3, npv1, busy3, busy1, to3, to1;
    logic [31:0] new_pc3, new_pc1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic mon_en = 1'b0;
    exp_t q3[$];
    exp_t q1[$];

    pipe_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(1024), .PC_W(32)) u_dut3 (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excp_req(excp_req), .ertn_req(ertn_req),
        .excp_entry(excp_entry), .era(era),
        .stall(stall3), .flush(flush3), .new_pc(new_pc3),
        .new_pc_valid(npv3), .busy(busy3), .stall_timeout(to3)
    );

    pipe_ctrl #(.FLUSH_CYCLES(1), .STALL_TIMEOUT(1024), .PC_W(32)) u_dut1 (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excp_req(excp_req), .ertn_req(ertn_req),
        .excp_entry(excp_entry), .era(era),
        .stall(stall1), .flush(flush1), .new_pc(new_pc1),
        .new_pc_valid(npv1), .busy(busy1), .stall_timeout(to1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Redirect monitor for the 3-cycle instance.
    always @(negedge clk) begin
        if (mon_en && npv3) begin
            if (q3.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut3_unexpected_strobe: got new_pc %h expected no strobe (cycle %0d)", new_pc3, cyc);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("dut3_new_pc", new_pc3, e.pc);
                check("dut3_strobe_cycle", cyc, e.cyc);
            end
        end
    end

    // Redirect monitor for the 1-cycle instance.
    always @(negedge clk) begin
        if (mon_en && npv1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut1_unexpected_strobe: got new_pc %h expected no strobe (cycle %0d)", new_pc1, cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1_new_pc", new_pc1, e.pc);
                check("dut1_strobe_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},   {26'd0, stall3}, 32'd0);
        check({tag, "_flush"},   {31'd0, flush3}, 32'd0);
        check({tag, "_busy"},    {31'd0, busy3},  32'd0);
        check({tag, "_npv"},     {31'd0, npv3},   32'd0);
        check({tag, "_new_pc"},  new_pc3,         32'd0);
        check({tag, "_timeout"}, {31'd0, to3},    32'd0);
    endtask

    // Issue a one-cycle request at cycle T and queue the expected redirects.
    task automatic fire(input logic e, input logic r, input logic [31:0] exp_pc, input logic push3);
        exp_t x;
        excp_req    = e;
        ertn_req    = r;
        stallreq_ex = 1'b0;
        x.pc  = exp_pc;
        x.cyc = cyc + 1;
        q1.push_back(x);
        if (push3) begin
            x.cyc = cyc + 3;
            q3.push_back(x);
        end
        @(negedge clk);
        check("flush_at_T", {31'd0, flush3}, 32'd0);
        cyc_end();
        excp_req = 1'b0;
        ertn_req = 1'b0;
    endtask

    // Cycles T+1..T+3 with stallreq_ex asserted: u_dut3 flushes, u_dut1 only at T+1.
    task automatic follow();
        for (int k = 1; k <= 3; k++) begin
            stallreq_ex = 1'b1;
            @(negedge clk);
            check("dut3_flush", {31'd0, flush3}, 32'd1);
            check("dut3_busy",  {31'd0, busy3},  32'd1);
            check("dut3_stall_in_flush", {26'd0, stall3}, 32'd0);
            check("dut1_flush", {31'd0, flush1}, (k == 1) ? 32'd1 : 32'd0);
            check("dut1_busy",  {31'd0, busy1},  (k == 1) ? 32'd1 : 32'd0);
            check("dut1_stall", {26'd0, stall1}, (k == 1) ? 32'd0 : 32'h0000_000f);
            cyc_end();
        end
        stallreq_ex = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
        excp_req = 1'b0; ertn_req = 1'b0;
        excp_entry = 32'h1c00_8000;
        era        = 32'h1c00_0100;
        cyc_end();
        cyc_end();
        @(negedge clk);
        check_all_zero("reset");
        cyc_end();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Stall priority
        stallreq_id = 1'b1;
        @(negedge clk); check("stall_id", {26'd0, stall3}, 32'h0000_0007); cyc_end();
        stallreq_mem = 1'b1;
        @(negedge clk); check("stall_id_mem", {26'd0, stall3}, 32'h0000_001f); cyc_end();
        stallreq_if = 1'b1; stallreq_ex = 1'b1;
        @(negedge clk); check("stall_all", {26'd0, stall3}, 32'h0000_001f); cyc_end();
        stallreq_mem = 1'b0; stallreq_id = 1'b0; stallreq_if = 1'b0;
        @(negedge clk); check("stall_ex", {26'd0, stall3}, 32'h0000_000f); cyc_end();
        stallreq_ex = 1'b0; stallreq_if = 1'b1;
        @(negedge clk); check("stall_if", {26'd0, stall3}, 32'h0000_0003); cyc_end();
        stallreq_if = 1'b0;
        @(negedge clk); check("stall_none", {26'd0, stall3}, 32'd0); cyc_end();

        // Exception alone, then both together, then ERTN alone (back-to-back for u_dut3)
        fire(1'b1, 1'b0, 32'h1c00_8000, 1'b1);
        follow();
        fire(1'b1, 1'b1, 32'h1c00_8000, 1'b1);
        follow();
        fire(1'b0, 1'b1, 32'h1c00_0100, 1'b1);
        follow();
        @(negedge clk);
        check("dut3_idle_flush", {31'd0, flush3}, 32'd0);
        check("dut3_idle_busy",  {31'd0, busy3},  32'd0);
        cyc_end();
        @(negedge clk);
        check("dut3_new_pc_hold", new_pc3, 32'h1c00_0100);
        check("dut1_new_pc_hold", new_pc1, 32'h1c00_0100);
        cyc_end();

        // Reset in the middle of a 3-cycle flush: no strobe from u_dut3
        fire(1'b1, 1'b0, 32'h1c00_8000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_flush", {31'd0, flush3}, 32'd1);
        cyc_end();
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("mid_flush_rst");
        cyc_end();
        for (int i = 0; i < 3; i++) cyc_end();

        // Watchdog: gap restarts the count, 1023 cycles is not enough, 1024 is
        stallreq_mem = 1'b1;
        for (int i = 0; i < 1000; i++) cyc_end();
        stallreq_mem = 1'b0;
        cyc_end();
        stallreq_mem = 1'b1;
        for (int i = 0; i < 1023; i++) cyc_end();
        stallreq_mem = 1'b0;
        @(negedge clk);
        check("timeout_1023", {31'd0, to3}, 32'd0);
        stallreq_mem = 1'b1;
        cyc_end();
        stallreq_mem = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            stallreq_mem = 1'b1;
            cyc_end();
        end
        stallreq_mem = 1'b0;
        @(negedge clk);
        check("timeout_1024", {31'd0, to3}, 32'd1);
        check("timeout_1024_dut1", {31'd0, to1}, 32'd1);
        cyc_end();
        for (int i = 0; i < 3; i++) cyc_end();
        @(negedge clk);
        check("timeout_sticky", {31'd0, to3}, 32'd1);
        cyc_end();

        check("dut3_pending_strobes", q3.size(), 32'd0);
        check("dut1_pending_strobes", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
